seg7_scan_ctrl: RTL and testbench

//  Time-multiplexed scan controller for a 4-digit common-anode 7-segment display.

---
 rtl/seg7_scan_ctrl.sv | 200 ++++++++++++++++++++
 tb/tb_seg7_scan_ctrl.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_ctrl.sv
// ----------------------------------------------------------------------------
// seg7_scan_ctrl
//   Time-multiplexed scan controller for a 4-digit common-anode 7-segment
//   display. One segment bus (and one external seg7Decode) is shared by the
//   four digits. Each digit owns a slot of REFRESH_DIV cycles: a blanking
//   part with every anode off, followed by a show part. Digit values, decimal
//   points and the leading-zero flag are snapshotted once per frame, so a
//   value that changes mid-frame never tears the displayed number.
//
// Parameters
//   REFRESH_DIV   clk cycles per digit slot (blank + show), >= 2
//   BLANK_CYCLES  all-anodes-off cycles at slot start, 0..REFRESH_DIV-1
//
// Ports
//   i_clk          system clock
//   i_rst          asynchronous reset, active-high
//   i_enable       1 = scanning, 0 = display dark
//   i_digits       four nibbles, [3:0] = digit 0 (rightmost)
//   i_dp_in        decimal point request per digit, active-high
//   i_blank_lz     1 = suppress leading zeros (digit 0 never suppressed)
//   o_an           anode enables, active-low, one-hot-low or all ones
//   o_nibble       value for the external seg7Decode
//   o_dp_n         decimal point, active-low
//   o_digit_idx    digit currently owning the segment bus
//   o_frame_done   one-cycle pulse when the digit 3 slot completes
//
// State table
//   state   | meaning
//   S_IDLE  | display dark, waiting for i_enable
//   S_BLANK | slot start, anodes off, nibble/dp already driven
//   S_SHOW  | anode of o_digit_idx on (unless suppressed)
// ----------------------------------------------------------------------------
module seg7_scan_ctrl #(
   parameter int REFRESH_DIV  = 50000,
   parameter int BLANK_CYCLES = 1000
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_enable,
   input  logic [15:0] i_digits,
   input  logic [3:0]  i_dp_in,
   input  logic        i_blank_lz,
   output logic [3:0]  o_an,
   output logic [3:0]  o_nibble,
   output logic        o_dp_n,
   output logic [1:0]  o_digit_idx,
   output logic        o_frame_done
);

   localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam logic [CW-1:0] SLOT_LAST  = CW'(REFRESH_DIV - 1);
   localparam logic [CW-1:0] BLANK_LAST = CW'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);
   localparam bit HAS_BLANK = (BLANK_CYCLES > 0);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_BLANK = 2'd1,
      S_SHOW  = 2'd2
   } state_t;

   state_t          r_state;
   logic [CW-1:0]   r_cnt;
   logic [1:0]      r_idx;
   logic [15:0]     r_snap_digits;
   logic [3:0]      r_snap_dp;
   logic            r_snap_lz;
   logic [3:0]      r_an;
   logic [3:0]      r_nibble;
   logic            r_dp_n;
   logic            r_frame_done;

   logic [1:0]      w_idx_next;
   state_t          w_slot_start;

   assign w_idx_next   = r_idx + 2'd1;
   // With no blanking a slot starts directly in the show state.
   assign w_slot_start = HAS_BLANK ? S_BLANK : S_SHOW;

   // Digit k>=1 is a leading zero when it and every digit above it are 0.
   function automatic logic f_supp(input logic [1:0]  idx,
                                   input logic [15:0] d,
                                   input logic        lz);
      logic [15:0] w_above;
      w_above = d >> {idx, 2'b00};
      return lz && (idx != 2'd0) && (w_above == 16'd0);
   endfunction

   function automatic logic [3:0] f_an(input logic        show,
                                       input logic [1:0]  idx,
                                       input logic [15:0] d,
                                       input logic        lz);
      if (show && !f_supp(idx, d, lz))
         return ~(4'b0001 << idx);
      return 4'b1111;
   endfunction

   function automatic logic [3:0] f_nib(input logic [1:0]  idx,
                                        input logic [15:0] d);
      return d[{idx, 2'b00} +: 4];
   endfunction

   function automatic logic f_dpn(input logic [1:0]  idx,
                                  input logic [3:0]  dp,
                                  input logic [15:0] d,
                                  input logic        lz);
      if (f_supp(idx, d, lz))
         return 1'b1;
      return ~dp[idx];
   endfunction

   // Outputs are computed from the values the state registers take on the
   // same edge, so they always match the state they are registered with.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state       <= S_IDLE;
         r_cnt         <= '0;
         r_idx         <= 2'd0;
         r_snap_digits <= 16'd0;
         r_snap_dp     <= 4'd0;
         r_snap_lz     <= 1'b0;
         r_an          <= 4'b1111;
         r_nibble      <= 4'd0;
         r_dp_n        <= 1'b1;
         r_frame_done  <= 1'b0;
      end else begin
         r_frame_done <= 1'b0;
         if (!i_enable) begin
            // Partial frame is discarded; no frame_done is issued.
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_idx    <= 2'd0;
            r_an     <= 4'b1111;
            r_nibble <= 4'd0;
            r_dp_n   <= 1'b1;
         end else begin
            case (r_state)
               S_IDLE: begin
                  r_snap_digits <= i_digits;
                  r_snap_dp     <= i_dp_in;
                  r_snap_lz     <= i_blank_lz;
                  r_idx         <= 2'd0;
                  r_cnt         <= '0;
                  r_state       <= w_slot_start;
                  r_an          <= f_an(!HAS_BLANK, 2'd0, i_digits, i_blank_lz);
                  r_nibble      <= f_nib(2'd0, i_digits);
                  r_dp_n        <= f_dpn(2'd0, i_dp_in, i_digits, i_blank_lz);
               end

               S_BLANK: begin
                  r_cnt <= r_cnt + 1'b1;
                  if (r_cnt == BLANK_LAST) begin
                     r_state <= S_SHOW;
                     r_an    <= f_an(1'b1, r_idx, r_snap_digits, r_snap_lz);
                  end
               end

               S_SHOW: begin
                  if (r_cnt == SLOT_LAST) begin
                     r_cnt   <= '0;
                     r_idx   <= w_idx_next;
                     r_state <= w_slot_start;
                     if (r_idx == 2'd3) begin
                        // Frame boundary: fresh snapshot feeds digit 0 now.
                        r_frame_done  <= 1'b1;
                        r_snap_digits <= i_digits;
                        r_snap_dp     <= i_dp_in;
                        r_snap_lz     <= i_blank_lz;
                        r_an          <= f_an(!HAS_BLANK, 2'd0, i_digits, i_blank_lz);
                        r_nibble      <= f_nib(2'd0, i_digits);
                        r_dp_n        <= f_dpn(2'd0, i_dp_in, i_digits, i_blank_lz);
                     end else begin
                        r_an     <= f_an(!HAS_BLANK, w_idx_next, r_snap_digits, r_snap_lz);
                        r_nibble <= f_nib(w_idx_next, r_snap_digits);
                        r_dp_n   <= f_dpn(w_idx_next, r_snap_dp, r_snap_digits, r_snap_lz);
                     end
                  end else begin
                     r_cnt <= r_cnt + 1'b1;
                  end
               end

               default: begin
                  r_state  <= S_IDLE;
                  r_cnt    <= '0;
                  r_idx    <= 2'd0;
                  r_an     <= 4'b1111;
                  r_nibble <= 4'd0;
                  r_dp_n   <= 1'b1;
               end
            endcase
         end
      end
   end

   assign o_an         = r_an;
   assign o_nibble     = r_nibble;
   assign o_dp_n       = r_dp_n;
   assign o_digit_idx  = r_idx;
   assign o_frame_done = r_frame_done;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Bench for seg7_scan_ctrl: two instances (BLANK_CYCLES=2 and 0, REFRESH_DIV=8)
// share stimulus. A reference model computes each cycle's expected outputs
// from the time since scanning started and the frame snapshot, pushes them
// into per-instance queues, and a monitor on the falling edge pops and compares.
module tb_seg7_scan_ctrl;
   localparam int R  = 8;
   localparam int BA = 2;

   typedef struct packed {
      logic [3:0] an;
      logic [3:0] nib;
      logic       dp_n;
      logic [1:0] idx;
      logic       fd;
   } obs_t;

   localparam obs_t RST_OBS = {4'hF, 4'h0, 1'b1, 2'd0, 1'b0};

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        enable = 1'b0;
   logic [15:0] digits = 16'd0;
   logic [3:0]  dp_in = 4'd0;
   logic        blank_lz = 1'b0;

   logic [3:0] a_an, a_nib, b_an, b_nib;
   logic       a_dp, a_fd, b_dp, b_fd;
   logic [1:0] a_idx, b_idx;

   seg7_scan_ctrl #(.REFRESH_DIV(R), .BLANK_CYCLES(BA)) u_dut_a (
      .i_clk(clk), .i_rst(rst), .i_enable(enable), .i_digits(digits),
      .i_dp_in(dp_in), .i_blank_lz(blank_lz), .o_an(a_an), .o_nibble(a_nib),
      .o_dp_n(a_dp), .o_digit_idx(a_idx), .o_frame_done(a_fd));

   seg7_scan_ctrl #(.REFRESH_DIV(R), .BLANK_CYCLES(0)) u_dut_b (
      .i_clk(clk), .i_rst(rst), .i_enable(enable), .i_digits(digits),
      .i_dp_in(dp_in), .i_blank_lz(blank_lz), .o_an(b_an), .o_nibble(b_nib),
      .o_dp_n(b_dp), .o_digit_idx(b_idx), .o_frame_done(b_fd));

   always #5 clk = ~clk;

   obs_t act_a, act_b;
   assign act_a = {a_an, a_nib, a_dp, a_idx, a_fd};
   assign act_b = {b_an, b_nib, b_dp, b_idx, b_fd};

   obs_t q_a[$];
   obs_t q_b[$];
   int   n_checks = 0;
   int   n_pass   = 0;

   // Reference model state: time since scanning started plus frame snapshot.
   bit          m_active = 1'b0;
   int          m_t = 0;
   logic [15:0] m_d = 16'd0;
   logic [3:0]  m_dp = 4'd0;
   logic        m_lz = 1'b0;

   function automatic obs_t expect_obs(int blank, bit active, int t,
                                       logic [15:0] d, logic [3:0] dp, logic lz);
      obs_t        o;
      int          ft, dig, pos;
      bit          show, supp;
      logic [15:0] above;
      o = RST_OBS;
      if (!active) return o;
      ft    = t % (4 * R);
      dig   = ft / R;
      pos   = ft % R;
      show  = (pos >= blank);
      above = d >> (4 * dig);
      supp  = lz && (dig != 0) && (above == 16'd0);
      o.idx  = dig[1:0];
      o.nib  = d[4*dig +: 4];
      o.an   = (show && !supp) ? ~(4'b0001 << dig) : 4'hF;
      o.dp_n = supp ? 1'b1 : ~dp[dig];
      o.fd   = (t > 0) && (ft == 0);
      return o;
   endfunction

   always @(posedge clk) begin
      if (rst) begin
         m_active = 1'b0;
         m_t      = 0;
      end else if (!enable) begin
         m_active = 1'b0;
         m_t      = 0;
      end else if (!m_active) begin
         m_active = 1'b1;
         m_t      = 0;
         m_d = digits; m_dp = dp_in; m_lz = blank_lz;
      end else begin
         m_t = m_t + 1;
         if (m_t % (4 * R) == 0) begin
            m_d = digits; m_dp = dp_in; m_lz = blank_lz;
         end
      end
      q_a.push_back(expect_obs(BA, m_active, m_t, m_d, m_dp, m_lz));
      q_b.push_back(expect_obs(0,  m_active, m_t, m_d, m_dp, m_lz));
   end

   task automatic cmp(input string nm, input obs_t exp, input obs_t act);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s @%0t: got an=%b nib=%h dp_n=%b idx=%0d fd=%b, want an=%b nib=%h dp_n=%b idx=%0d fd=%b",
                    nm, $time, act.an, act.nib, act.dp_n, act.idx, act.fd,
                    exp.an, exp.nib, exp.dp_n, exp.idx, exp.fd);
   endtask

   always @(negedge clk) begin
      if (q_a.size() > 0) cmp("scan_blank2", q_a.pop_front(), act_a);
      if (q_b.size() > 0) cmp("scan_blank0", q_b.pop_front(), act_b);
   end

   task automatic run(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic pulse_reset();
      @(negedge clk);
      #2 rst = 1'b1;
      #1;
      cmp("async_rst_a", RST_OBS, act_a);
      cmp("async_rst_b", RST_OBS, act_b);
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      logic [15:0] rd;
      rst = 1'b1;
      run(3);
      rst = 1'b0;
      run(4);                                    // idle, enable low

      digits = 16'h4321; dp_in = 4'b0101; blank_lz = 1'b0;
      enable = 1'b1;
      run(70);                                   // scan order, frame pulses
      pulse_reset();                             // mid-show async reset
      run(20);

      enable = 1'b0; run(2);
      digits = 16'h0050; blank_lz = 1'b1; dp_in = 4'b1111;
      enable = 1'b1; run(36);                    // leading zeros
      enable = 1'b0; run(2);
      digits = 16'h0000;
      enable = 1'b1; run(36);                    // all zero -> only digit 0

      enable = 1'b0; run(2);
      digits = 16'h1111; blank_lz = 1'b0; dp_in = 4'b0000;
      enable = 1'b1; run(10);
      digits = 16'h2222; run(60);                // snapshot holds mid-frame

      enable = 1'b0; run(2);
      enable = 1'b1; run(20);
      enable = 1'b0; run(5);                     // drop discards frame
      enable = 1'b1; run(40);

      for (int i = 0; i < 40; i++) begin
         rd = 16'($urandom);
         for (int k = 0; k < 4; k++)
            if ($urandom_range(0, 1) == 1) rd[4*k +: 4] = 4'h0;
         digits   = rd;
         dp_in    = 4'($urandom);
         blank_lz = 1'($urandom);
         enable   = ($urandom_range(0, 3) != 0);
         run($urandom_range(1, 50));
      end
      enable = 1'b1; run(40);
      enable = 1'b0; run(3);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
